cass_decoder: RTL and testbench

CASS_DECODER -- requirements
Module: cass_decoder

---
 rtl/cass_dec_pkg.sv | 19 +
 rtl/cass_fifo.sv | 49 ++++
 rtl/cass_decoder.sv | 180 ++++++++++++++++++
 tb/tb_cass_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cass_dec_pkg.sv
// Shared types and constants for the cassette pulse decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cass_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DATA = 2'd2
    } cass_state_e;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [1:0] PULSE_LEVEL = 2'b01;

    localparam int HALF_TICKS_DEF    = 1750;
    localparam int TIMEOUT_TICKS_DEF = 8000;
    localparam int FIFO_DEPTH_DEF    = 4;

endpackage

// File: rtl/cass_fifo.sv
// Show-ahead synchronous FIFO holding decoded bytes.
// Latency: a push is visible on pop_dat_o / !empty_o right after the push edge.
// Backpressure: push while full is refused unless a pop happens on the same edge.
// Ports: clk, reset_n | push_i, push_dat_i | pop_i, pop_dat_o | full_o, empty_o
module cass_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         do_pop, do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);

    // Hold the output at zero while empty so nothing stale shows through.
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/cass_decoder.sv
// Cassette port decoder: turns clock/data pulses written to port FF into bytes.
// Latency: a completed byte is pushed on the resolving edge; byte_valid follows that edge.
// Backpressure: byte_valid/byte_ready; bytes completing into a full FIFO are dropped (sticky overflow).
// Ports: clk, reset_n, ce | io_wr, io_data | byte_data, byte_valid, byte_ready | motor, sync_seen, overflow
// Build option: CASS_DEC_SYNC_EN enables HUNT/0xA5 sync framing; otherwise framing starts at motor on.
module cass_decoder
    import cass_dec_pkg::*;
#(
    parameter int HALF_TICKS    = HALF_TICKS_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       io_wr,
    input  logic [7:0] io_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       motor,
    output logic       sync_seen,
    output logic       overflow
);
    localparam logic [15:0] HALF_L = 16'(HALF_TICKS);
    localparam logic [15:0] TMO_L  = 16'(TIMEOUT_TICKS);
`ifdef CASS_DEC_SYNC_EN
    localparam cass_state_e START_ST = HUNT;
`else
    localparam cass_state_e START_ST = DATA;
`endif

    cass_state_e state_q, state_d;
    logic        motor_q, motor_d;
    logic [1:0]  lvl_q, lvl_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cell_open_q, cell_open_d;
    logic        data_seen_q, data_seen_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic        sync_seen_q, sync_seen_d;
    logic        overflow_q, overflow_d;

    logic        wr, pulse, resolve, tmo, push, pop, fifo_full, fifo_empty;
    logic [7:0]  sr_nxt;

    assign wr     = io_wr && ce;
    assign pulse  = wr && (io_data[1:0] == PULSE_LEVEL) && (lvl_q != PULSE_LEVEL);
    assign sr_nxt = {sr_q[6:0], data_seen_q};
    assign pop    = byte_ready && byte_valid;

    always_comb begin
        state_d     = state_q;
        motor_d     = motor_q;
        lvl_d       = lvl_q;
        cnt_d       = cnt_q;
        cell_open_d = cell_open_q;
        data_seen_d = data_seen_q;
        sr_d        = sr_q;
        bcnt_d      = bcnt_q;
        sync_seen_d = sync_seen_q;
        overflow_d  = overflow_q;
        resolve     = 1'b0;
        tmo         = 1'b0;
        push        = 1'b0;

        if (wr) begin
            motor_d = io_data[2];
            lvl_d   = io_data[1:0];
        end
        if (ce && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;

        if (wr && !io_data[2]) begin
            // Motor off: drop the partial byte; queued bytes stay for the consumer.
            state_d     = IDLE;
            cell_open_d = 1'b0;
            sr_d        = '0;
            bcnt_d      = '0;
        end else if (wr && !motor_q) begin
            state_d     = START_ST;
            sync_seen_d = 1'b0;
            overflow_d  = 1'b0;
            cell_open_d = 1'b0;
            sr_d        = '0;
            bcnt_d      = '0;
        end else if (state_q != IDLE) begin
            if (pulse) begin
                if (!cell_open_q) begin
                    cell_open_d = 1'b1;
                    data_seen_d = 1'b0;
                    cnt_d       = '0;
                end else if (cnt_q < HALF_L) begin
                    data_seen_d = 1'b1;
                end else begin
                    // Late pulse closes the cell and opens the next one.
                    resolve     = 1'b1;
                    data_seen_d = 1'b0;
                    cnt_d       = '0;
                end
            end else if (cell_open_q && cnt_q >= TMO_L) begin
                resolve     = 1'b1;
                tmo         = 1'b1;
                cell_open_d = 1'b0;
                data_seen_d = 1'b0;
            end

            if (resolve) begin
                sr_d = sr_nxt;
                if (state_q == DATA) begin
                    bcnt_d = bcnt_q + 3'd1;
                    push   = (bcnt_q == 3'd7);
                end
`ifdef CASS_DEC_SYNC_EN
                else if (!tmo && sr_nxt == SYNC_BYTE) begin
                    sync_seen_d = 1'b1;
                    state_d     = DATA;
                    bcnt_d      = '0;
                end
`endif
                if (tmo) begin
                    state_d = START_ST;
                    sr_d    = '0;
                    bcnt_d  = '0;
                end
            end
        end

        if (push && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            motor_q     <= 1'b0;
            lvl_q       <= '0;
            cnt_q       <= '0;
            cell_open_q <= 1'b0;
            data_seen_q <= 1'b0;
            sr_q        <= '0;
            bcnt_q      <= '0;
            sync_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            motor_q     <= motor_d;
            lvl_q       <= lvl_d;
            cnt_q       <= cnt_d;
            cell_open_q <= cell_open_d;
            data_seen_q <= data_seen_d;
            sr_q        <= sr_d;
            bcnt_q      <= bcnt_d;
            sync_seen_q <= sync_seen_d;
            overflow_q  <= overflow_d;
        end
    end

    cass_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_dat_i (sr_nxt),
        .pop_i      (byte_ready),
        .pop_dat_o  (byte_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign byte_valid = !fifo_empty;
    assign motor      = motor_q;
    assign overflow   = overflow_q;
`ifdef CASS_DEC_SYNC_EN
    assign sync_seen  = sync_seen_q;
`else
    assign sync_seen  = 1'b0;
`endif

endmodule

// File: tb/tb_cass_decoder.sv
// Directed bench for cass_decoder with scaled timing (HALF=10, TIMEOUT=45 ticks).
// ce is high on every other clk, so one tick is two clks.
module tb_cass_decoder;
    import cass_dec_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n, ce, io_wr, byte_ready;
    logic [7:0] io_data;
    logic [7:0] byte_data;
    logic       byte_valid, motor, sync_seen, overflow;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] got_q [$];

    cass_decoder #(
        .HALF_TICKS    (10),
        .TIMEOUT_TICKS (45),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .io_wr      (io_wr),
        .io_data    (io_data),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .motor      (motor),
        .sync_seen  (sync_seen),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so a negedge sample predicts the next pop.
    always @(negedge clk) begin
        if (reset_n && byte_valid && byte_ready) got_q.push_back(byte_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input logic w, input logic [7:0] d);
        io_wr = w;
        if (w) io_data = d;
        ce = 1'b1;
        @(posedge clk); #1;
        io_wr = 1'b0;
        ce    = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic clocks(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Closing clock pulse; optionally pops on the very same edge.
    task automatic clock_edge(input logic pop);
        io_wr = 1'b1; ce = 1'b1; io_data = 8'h05;
        if (pop) byte_ready = 1'b1;
        @(posedge clk); #1;
        if (pop) byte_ready = 1'b0;
        io_wr = 1'b0; ce = 1'b0;
        @(posedge clk); #1;
    endtask

    // Body of a cell opened by the previous clock pulse: level low, optional data pulse at 3 ticks.
    task automatic bit_body(input logic b);
        tick(1'b1, 8'h04);
        if (b) begin
            idle(2);
            tick(1'b1, 8'h05);
            tick(1'b1, 8'h04);
            idle(14);
        end else begin
            idle(18);
        end
    endtask

    task automatic send_bit(input logic b, input logic pop);
        bit_body(b);
        clock_edge(pop);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    initial begin
        int w;
        logic [7:0] v;
        reset_n = 1'b1; ce = 1'b0; io_wr = 1'b0; io_data = 8'h00; byte_ready = 1'b0;
        #2 reset_n = 1'b0;
        // Writes during reset must be ignored.
        io_wr = 1'b1; ce = 1'b1; io_data = 8'h05;
        clocks(3);
        chk("rst_motor", 32'(motor), 32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_data", 32'(byte_data), 32'd0);
        chk("rst_sync", 32'(sync_seen), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        chk("rst_lvl", 32'(dut.lvl_q), 32'd0);
        io_wr = 1'b0; ce = 1'b0; io_data = 8'h00;
        @(posedge clk); #1;
        reset_n = 1'b1;
        clocks(2);

        // Motor on.
        tick(1'b1, 8'h04);
        chk("motor_on", 32'(motor), 32'd1);
`ifdef CASS_DEC_SYNC_EN
        chk("state_hunt", 32'(dut.state_q), 32'(HUNT));
`else
        chk("state_data", 32'(dut.state_q), 32'(DATA));
`endif
        // io_wr without ce is not a write.
        io_wr = 1'b1; io_data = 8'h00;
        @(posedge clk); #1;
        io_wr = 1'b0;
        chk("wr_needs_ce", 32'(motor), 32'd1);

        // Pulses at 0, 19, 22, 38 ticks: the late pulse at 19 closes cell 1 empty (0),
        // the early pulse at 3 ticks into cell 2 marks it, and the pulse at 38 closes it (1).
        tick(1'b1, 8'h05);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("two_bits_sr", 32'(dut.sr_q), 32'h01);
        chk("no_byte_yet", 32'(byte_valid), 32'd0);

        // Motor off/on realigns framing.
        tick(1'b1, 8'h00);
        chk("off_idle", 32'(dut.state_q), 32'(IDLE));
        chk("off_motor", 32'(motor), 32'd0);
        tick(1'b1, 8'h04);

        // Main stream with the consumer always ready.
        byte_ready = 1'b1;
        got_q.delete();
        tick(1'b1, 8'h05);
`ifdef CASS_DEC_SYNC_EN
        repeat (256) send_bit(1'b0, 1'b0);
        chk("no_sync_on_zeros", 32'(sync_seen), 32'd0);
        send_byte(8'hA5);
        chk("sync_seen", 32'(sync_seen), 32'd1);
        chk("sync_to_data", 32'(dut.state_q), 32'(DATA));
        send_byte(8'h55);
        send_byte(8'h3C);
        clocks(4);
        chk("stream_cnt", 32'(got_q.size()), 32'd2);
        chk("stream_0", 32'(got_q[0]), 32'h55);
        chk("stream_1", 32'(got_q[1]), 32'h3C);
`else
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h55);
        send_byte(8'h3C);
        clocks(4);
        chk("sync_tied_low", 32'(sync_seen), 32'd0);
        chk("stream_cnt", 32'(got_q.size()), 32'd4);
        chk("stream_0", 32'(got_q[0]), 32'h00);
        chk("stream_1", 32'(got_q[1]), 32'hA5);
        chk("stream_2", 32'(got_q[2]), 32'h55);
        chk("stream_3", 32'(got_q[3]), 32'h3C);
`endif

        // Overflow: consumer stalled, six bytes into four slots.
        byte_ready = 1'b0;
        got_q.delete();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        chk("head_11", 32'(byte_data), 32'h11);
        send_byte(8'h55);
        send_byte(8'h66);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("head_kept", 32'(byte_data), 32'h11);
        // 0x77 completes on the same edge as a pop, so it must be accepted.
        v = 8'h77;
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
        send_bit(v[0], 1'b1);
        chk("head_22", 32'(byte_data), 32'h22);
        clocks(3);
        chk("head_stable", 32'(byte_data), 32'h22);
        byte_ready = 1'b1;
        clocks(6);
        byte_ready = 1'b0;
        chk("drain_cnt", 32'(got_q.size()), 32'd5);
        chk("drain_0", 32'(got_q[0]), 32'h11);
        chk("drain_3", 32'(got_q[3]), 32'h44);
        chk("accept_on_pop", 32'(got_q[4]), 32'h77);
        chk("drained", 32'(byte_valid), 32'd0);
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h04);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        tick(1'b1, 8'h05);
`ifdef CASS_DEC_SYNC_EN
        send_byte(8'hA5);
`endif

        // 0x81 whose last cell is only closed by the tape-stop timeout.
        got_q.delete();
        v = 8'h81;
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
        bit_body(1'b1);  // ends 19 ticks in; check at 19+... see below
        // bit_body left the counter at 19; six more ticks is still short of 45.
        idle(6);
        chk("no_early_tmo", 32'(byte_valid), 32'd0);
        // Counter now 25; it reaches 45 after 20 ticks and the next edge resolves.
        w = 0;
        while (w < 60 && !byte_valid) begin
            idle(1);
            w++;
        end
        chk("tmo_latency", 32'(w), 32'd20);
        chk("tmo_valid", 32'(byte_valid), 32'd1);
        chk("tmo_byte", 32'(byte_data), 32'h81);
        chk("tmo_cell_closed", 32'(dut.cell_open_q), 32'd0);
`ifdef CASS_DEC_SYNC_EN
        chk("tmo_to_hunt", 32'(dut.state_q), 32'(HUNT));
`else
        chk("tmo_to_data", 32'(dut.state_q), 32'(DATA));
`endif
        byte_ready = 1'b1;
        clocks(2);
        byte_ready = 1'b0;

        // One queued byte, then motor off mid-byte.
        got_q.delete();
        tick(1'b1, 8'h05);
`ifdef CASS_DEC_SYNC_EN
        send_byte(8'hA5);
`endif
        v = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
        bit_body(v[0]);
        chk("valid_before_push", 32'(byte_valid), 32'd0);
        io_wr = 1'b1; ce = 1'b1; io_data = 8'h05;
        @(posedge clk); #1;
        io_wr = 1'b0; ce = 1'b0;
        chk("valid_after_push", 32'(byte_valid), 32'd1);
        @(posedge clk); #1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        tick(1'b1, 8'h00);
        chk("offmid_idle", 32'(dut.state_q), 32'(IDLE));
        idle(60);
        chk("offmid_head", 32'(byte_data), 32'h5A);
        byte_ready = 1'b1;
        clocks(3);
        byte_ready = 1'b0;
        chk("offmid_cnt", 32'(got_q.size()), 32'd1);
        chk("offmid_empty", 32'(byte_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
